// File: rtl/genius_ctrl_param.sv
// Purpose: parametrised GENIUS game controller. It tracks the difficulty level, the round number, win detection and the user timeout.
// Latency: the datapath controls are a Moore decode of the state. round, won and lost are registered and change on the edge that enters the state.
// Backpressure: none. Each state waits for its own handshake input (enter, end_FPGA, end_User, match).
//
// Ports:
//   CLOCK, reset (async active-low)
//   enter, level[1:0], end_FPGA, end_User, key_pressed, match   - game inputs
//   R1, R2, E1, E2, E3, E4, SEL                                  - datapath controls
//   round[RW-1:0], won, lost                                     - game status
module genius_ctrl_param #(
    parameter int MAX_ROUNDS     = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int RW             = $clog2(MAX_ROUNDS + 1),
    parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic          CLOCK,
    input  logic          reset,
    input  logic          enter,
    input  logic [1:0]    level,
    input  logic          end_FPGA,
    input  logic          end_User,
    input  logic          key_pressed,
    input  logic          match,
    output logic          R1,
    output logic          R2,
    output logic          E1,
    output logic          E2,
    output logic          E3,
    output logic          E4,
    output logic          SEL,
    output logic [RW-1:0] round,
    output logic          won,
    output logic          lost
);

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        SETUP      = 3'd1,
        PLAY_FPGA  = 3'd2,
        PLAY_USER  = 3'd3,
        CHECK      = 3'd4,
        NEXT_ROUND = 3'd5,
        RESULT     = 3'd6
    } state_t;

    localparam int QUARTER = MAX_ROUNDS / 4;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [RW-1:0] target;
    logic          tmo_hit;
    logic [6:0]    ctl;

    // The terminal count is only honoured when no key arrives in the same cycle.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) && !key_pressed;

    // State register
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:       state_nxt = SETUP;
            SETUP:      if (enter) state_nxt = PLAY_FPGA;
            PLAY_FPGA:  if (end_FPGA) state_nxt = PLAY_USER;
            PLAY_USER: begin
                // A keypress alone only reloads the timer.
                // If end_User arrives with the keypress, the entry is complete.
                if (key_pressed) begin
                    if (end_User) state_nxt = CHECK;
                end else if (tmo_hit) begin
                    state_nxt = RESULT;
                end else if (end_User) begin
                    state_nxt = CHECK;
                end
            end
            CHECK:      state_nxt = match ? NEXT_ROUND : RESULT;
            NEXT_ROUND: state_nxt = (round == target) ? RESULT : PLAY_FPGA;
            RESULT:     if (enter) state_nxt = INIT;
            default:    state_nxt = INIT;
        endcase
    end

    // Output decode {R1,R2,E1,E2,E3,E4,SEL}
    always_comb begin
        ctl = 7'b0000000;
        case (state)
            INIT:       ctl = 7'b1100000;
            SETUP:      ctl = 7'b0010000;
            PLAY_FPGA:  ctl = 7'b0000100;
            PLAY_USER:  ctl = 7'b0001000;
            CHECK:      ctl = 7'b0000010;
            NEXT_ROUND: ctl = 7'b0100000;
            RESULT:     ctl = 7'b0000001;
            default:    ctl = 7'b0000000;
        endcase
    end

    assign {R1, R2, E1, E2, E3, E4, SEL} = ctl;

    // Game status registers: round, target, timeout counter and the result flags
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            round   <= '0;
            won     <= 1'b0;
            lost    <= 1'b0;
            tmo_cnt <= '0;
            target  <= RW'(MAX_ROUNDS);
        end else begin
            case (state)
                INIT: begin
                    round <= '0;
                    won   <= 1'b0;
                    lost  <= 1'b0;
                end
                SETUP: begin
                    if (enter) begin
                        round  <= RW'(1);
                        // The level is latched here and only here. Later changes wait for the next game.
                        target <= RW'((int'(level) + 1) * QUARTER);
                    end
                end
                PLAY_FPGA: begin
                    if (end_FPGA) tmo_cnt <= '0;
                end
                PLAY_USER: begin
                    if (key_pressed) begin
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        lost <= 1'b1;
                    end else if (!end_User) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (!match) lost <= 1'b1;
                end
                NEXT_ROUND: begin
                    // round stops at target, so it can never wrap
                    if (round == target) won <= 1'b1;
                    else                 round <= round + 1'b1;
                end
                RESULT: begin
                    // The flags are valid only in RESULT, so they clear as the game restarts.
                    if (enter) begin
                        won  <= 1'b0;
                        lost <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
